// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// SPI responder that works entirely in the clk domain. SCLK, CS and MOSI are
// oversampled asynchronous inputs. No logic is clocked by SCLK.
//
// Ports:
//   clk, rst_n      system clock (>= 8x SCLK), async active-low reset
//   tx_data_i       next frame to transmit, captured on each frame load
//   tx_ack_o        one-clk pulse when tx_data_i has been captured
//   rx_data_o       last complete received frame, held until the next one
//   rx_valid_o      one-clk pulse when rx_data_o updates
//   frame_err_o     one-clk pulse when CS deasserts mid-frame
//   busy_o          high while the synchronised CS is low
//   f_cnt           wrapping count of complete frames received
//   SCLK, CS, MOSI  serial inputs from the master (asynchronous)
//   MISO, MISO_oe   serial output and its pad enable
// -----------------------------------------------------------------------------
module spi_slave #(
    parameter int unsigned CPOL    = 0,
    parameter int unsigned CPHA    = 0,
    parameter int unsigned F_SIZE  = 8,
    parameter int unsigned C_SIZE  = $clog2(F_SIZE),
    parameter int unsigned FC_SIZE = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [F_SIZE-1:0]  tx_data_i,
    output logic               tx_ack_o,
    output logic [F_SIZE-1:0]  rx_data_o,
    output logic               rx_valid_o,
    output logic               frame_err_o,
    output logic               busy_o,
    output logic [FC_SIZE-1:0] f_cnt,
    input  logic               SCLK,
    input  logic               CS,
    input  logic               MOSI,
    output logic               MISO,
    output logic               MISO_oe
);

    localparam logic              IDLE_LVL = 1'(CPOL);
    localparam logic [C_SIZE-1:0] LAST_BIT = C_SIZE'(F_SIZE - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t              state;
    logic [2:0]          sclk_q;
    logic [2:0]          cs_q;
    logic [1:0]          mosi_q;
    logic [F_SIZE-1:0]   tx_shift;
    logic [F_SIZE-1:0]   rx_shift;
    logic [C_SIZE-1:0]   bit_cnt;
    logic                first_shift;
    logic                frame_done;

    // Synchronised levels (stage 1) and the delayed copy used for edges (stage 2)
    logic sclk_s, sclk_d, cs_s, cs_d, mosi_s;
    logic lead_edge, trail_edge, sample_edge, shift_edge, cs_fall, cs_rise;

    assign sclk_s = sclk_q[1];
    assign sclk_d = sclk_q[2];
    assign cs_s   = cs_q[1];
    assign cs_d   = cs_q[2];
    // MOSI at the same synchroniser depth as the SCLK level that flags an edge
    assign mosi_s = mosi_q[1];

    assign lead_edge   = (sclk_s != IDLE_LVL) && (sclk_d == IDLE_LVL);
    assign trail_edge  = (sclk_s == IDLE_LVL) && (sclk_d != IDLE_LVL);
    assign sample_edge = (CPHA == 0) ? lead_edge  : trail_edge;
    assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;
    assign cs_fall     = !cs_s && cs_d;
    assign cs_rise     = cs_s && !cs_d;

    assign MISO = tx_shift[F_SIZE-1];

    // Synchronisers, frame FSM, shift registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q      <= {3{IDLE_LVL}};
            cs_q        <= 3'b111;
            mosi_q      <= 2'b00;
            state       <= IDLE;
            tx_shift    <= '0;
            rx_shift    <= '0;
            rx_data_o   <= '0;
            bit_cnt     <= '0;
            f_cnt       <= '0;
            first_shift <= 1'b0;
            frame_done  <= 1'b0;
            tx_ack_o    <= 1'b0;
            rx_valid_o  <= 1'b0;
            frame_err_o <= 1'b0;
            busy_o      <= 1'b0;
            MISO_oe     <= 1'b0;
        end else begin
            sclk_q      <= {sclk_q[1:0], SCLK};
            cs_q        <= {cs_q[1:0], CS};
            mosi_q      <= {mosi_q[0], MOSI};
            tx_ack_o    <= 1'b0;
            rx_valid_o  <= 1'b0;
            frame_err_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state       <= ACTIVE;
                        tx_shift    <= tx_data_i;
                        tx_ack_o    <= 1'b1;
                        bit_cnt     <= '0;
                        first_shift <= (CPHA != 0);
                        frame_done  <= 1'b0;
                        busy_o      <= 1'b1;
                        MISO_oe     <= 1'b1;
                    end
                end

                ACTIVE: begin
                    if (cs_rise) begin
                        // CS rise wins over any SCLK edge seen in the same cycle
                        state   <= IDLE;
                        busy_o  <= 1'b0;
                        MISO_oe <= 1'b0;
                        if (bit_cnt != '0) begin
                            frame_err_o <= 1'b1;
                        end
                    end else if (sample_edge) begin
                        rx_shift <= {rx_shift[F_SIZE-2:0], mosi_s};
                        if (bit_cnt == LAST_BIT) begin
                            rx_data_o  <= {rx_shift[F_SIZE-2:0], mosi_s};
                            rx_valid_o <= 1'b1;
                            f_cnt      <= f_cnt + FC_SIZE'(1);
                            bit_cnt    <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            bit_cnt    <= bit_cnt + C_SIZE'(1);
                            frame_done <= 1'b0;
                        end
                    end else if (shift_edge) begin
                        if (first_shift) begin
                            // CPHA=1: MSB has been on MISO since CS fall
                            first_shift <= 1'b0;
                        end else if (frame_done) begin
                            // Back-to-back frame under the same CS: reload
                            tx_shift   <= tx_data_i;
                            tx_ack_o   <= 1'b1;
                            frame_done <= 1'b0;
                        end else begin
                            tx_shift <= {tx_shift[F_SIZE-2:0], 1'b0};
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
// Directed bench for spi_slave. There are four instances:
//   0: mode 0
//   1: mode 3
//   2: mode 1
//   3: mode 0 with a 2-bit frame counter
// A master task bit-bangs SCLK/CS/MOSI for one instance at a time. Expected
// receive words and frame counts are queued when a frame is sent and popped
// on rx_valid_o. Each tx_ack_o queues the tx word it captured, and the MISO
// bits the master collects are popped against that queue.
// -----------------------------------------------------------------------------
module tb_spi_slave;

    localparam int HALF = 8;   // SCLK half period in clk cycles

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] fc;
    } rx_exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] sclk;
    logic [3:0] cs;
    logic       mosi;
    logic [7:0] tx_data [4];
    logic [3:0] tx_ack, rx_valid, frame_err, busy, miso, miso_oe;
    logic [7:0] rx_data [4];
    logic [7:0] f_cnt   [4];
    logic [1:0] f_cnt3;

    assign f_cnt[3] = {6'b0, f_cnt3};

    int n_assert = 0;
    int n_fail   = 0;
    int ack_cnt   [4] = '{0, 0, 0, 0};
    int valid_cnt [4] = '{0, 0, 0, 0};
    int err_cnt   [4] = '{0, 0, 0, 0};
    int fc_model  [4] = '{0, 0, 0, 0};
    int fc_mod    [4] = '{256, 256, 256, 4};
    int ack_snap = 0;

    logic [7:0] tx_exp  [4][$];
    logic [7:0] tx_plan [4][$];
    rx_exp_t    rx_q    [4][$];

    spi_slave #(.CPOL(0), .CPHA(0), .F_SIZE(8), .FC_SIZE(8)) u_m0 (
        .clk(clk), .rst_n(rst_n), .tx_data_i(tx_data[0]), .tx_ack_o(tx_ack[0]),
        .rx_data_o(rx_data[0]), .rx_valid_o(rx_valid[0]), .frame_err_o(frame_err[0]),
        .busy_o(busy[0]), .f_cnt(f_cnt[0]), .SCLK(sclk[0]), .CS(cs[0]), .MOSI(mosi),
        .MISO(miso[0]), .MISO_oe(miso_oe[0]));

    spi_slave #(.CPOL(1), .CPHA(1), .F_SIZE(8), .FC_SIZE(8)) u_m3 (
        .clk(clk), .rst_n(rst_n), .tx_data_i(tx_data[1]), .tx_ack_o(tx_ack[1]),
        .rx_data_o(rx_data[1]), .rx_valid_o(rx_valid[1]), .frame_err_o(frame_err[1]),
        .busy_o(busy[1]), .f_cnt(f_cnt[1]), .SCLK(sclk[1]), .CS(cs[1]), .MOSI(mosi),
        .MISO(miso[1]), .MISO_oe(miso_oe[1]));

    spi_slave #(.CPOL(0), .CPHA(1), .F_SIZE(8), .FC_SIZE(8)) u_m1 (
        .clk(clk), .rst_n(rst_n), .tx_data_i(tx_data[2]), .tx_ack_o(tx_ack[2]),
        .rx_data_o(rx_data[2]), .rx_valid_o(rx_valid[2]), .frame_err_o(frame_err[2]),
        .busy_o(busy[2]), .f_cnt(f_cnt[2]), .SCLK(sclk[2]), .CS(cs[2]), .MOSI(mosi),
        .MISO(miso[2]), .MISO_oe(miso_oe[2]));

    spi_slave #(.CPOL(0), .CPHA(0), .F_SIZE(8), .FC_SIZE(2)) u_fc2 (
        .clk(clk), .rst_n(rst_n), .tx_data_i(tx_data[3]), .tx_ack_o(tx_ack[3]),
        .rx_data_o(rx_data[3]), .rx_valid_o(rx_valid[3]), .frame_err_o(frame_err[3]),
        .busy_o(busy[3]), .f_cnt(f_cnt3), .SCLK(sclk[3]), .CS(cs[3]), .MOSI(mosi),
        .MISO(miso[3]), .MISO_oe(miso_oe[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clk step: on the falling edge, service acks, rx scoreboard and errors
    task automatic tick();
        rx_exp_t e;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (tx_ack[i]) begin
                ack_cnt[i]++;
                tx_exp[i].push_back(tx_data[i]);
                if (tx_plan[i].size() > 0) tx_data[i] = tx_plan[i].pop_front();
            end
            if (rx_valid[i]) begin
                valid_cnt[i]++;
                if (rx_q[i].size() == 0) begin
                    check($sformatf("rx_unexpected[%0d]", i), 32'(1), 32'(0));
                end else begin
                    e = rx_q[i].pop_front();
                    check($sformatf("rx_data[%0d]", i), 32'(rx_data[i]), 32'(e.data));
                    check($sformatf("f_cnt_at_valid[%0d]", i), 32'(f_cnt[i]), 32'(e.fc));
                end
            end
            if (frame_err[i]) err_cnt[i]++;
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) tick();
    endtask

    // Master side of one frame (or a partial one) on instance idx
    task automatic xfer(input int idx, input int cpol, input int cpha,
                        input logic [7:0] tx, input int nbits,
                        input bit fall_cs, input bit raise_cs,
                        output logic [7:0] m);
        logic [7:0] exp;
        rx_exp_t    e;
        m = 8'h00;
        if (nbits == 8) begin
            fc_model[idx] = (fc_model[idx] + 1) % fc_mod[idx];
            e.data = tx;
            e.fc   = 8'(fc_model[idx]);
            rx_q[idx].push_back(e);
        end
        if (fall_cs) begin
            tx_exp[idx].delete();
            cs[idx] = 1'b0;
            wait_clk(HALF);
        end
        for (int b = 0; b < nbits; b++) begin
            if (cpha == 0) begin
                mosi = tx[7-b];
                wait_clk(HALF);
                sclk[idx] = ~1'(cpol);
                m = {m[6:0], miso[idx]};
                wait_clk(HALF);
                ack_snap = ack_cnt[idx];
                sclk[idx] = 1'(cpol);
            end else begin
                sclk[idx] = ~1'(cpol);
                mosi = tx[7-b];
                wait_clk(HALF);
                sclk[idx] = 1'(cpol);
                m = {m[6:0], miso[idx]};
                wait_clk(HALF);
                ack_snap = ack_cnt[idx];
            end
        end
        if (cpha == 0) wait_clk(HALF);
        if (nbits == 8) begin
            if (tx_exp[idx].size() == 0) begin
                check($sformatf("tx_ack_missing[%0d]", idx), 32'(0), 32'(1));
            end else begin
                exp = tx_exp[idx].pop_front();
                check($sformatf("miso_frame[%0d]", idx), 32'(m), 32'(exp));
            end
        end
        if (raise_cs) begin
            cs[idx] = 1'b1;
            wait_clk(HALF);
        end
    endtask

    initial begin
        logic [7:0] m;
        int         a0, v0, e0;
        int         fc_seq [5];
        fc_seq = '{1, 2, 3, 0, 1};

        rst_n = 1'b0;
        sclk  = 4'b0010;
        cs    = 4'b1111;
        mosi  = 1'b0;
        for (int i = 0; i < 4; i++) tx_data[i] = 8'h00;
        wait_clk(4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_rx_data[%0d]", i), 32'(rx_data[i]), 32'(0));
            check($sformatf("rst_f_cnt[%0d]", i), 32'(f_cnt[i]), 32'(0));
            check($sformatf("rst_busy[%0d]", i), 32'(busy[i]), 32'(0));
            check($sformatf("rst_miso_oe[%0d]", i), 32'(miso_oe[i]), 32'(0));
            check($sformatf("rst_miso[%0d]", i), 32'(miso[i]), 32'(0));
        end
        rst_n = 1'b1;
        wait_clk(4);

        // Mode 0 single frame: send 3C, return A5
        tx_data[0] = 8'hA5;
        a0 = ack_cnt[0];
        v0 = valid_cnt[0];
        xfer(0, 0, 0, 8'h3C, 8, 1'b1, 1'b1, m);
        check("m0_miso_bits", 32'(m), 32'hA5);
        check("m0_rx_data", 32'(rx_data[0]), 32'h3C);
        check("m0_valid_pulses", 32'(valid_cnt[0] - v0), 32'(1));
        check("m0_f_cnt", 32'(f_cnt[0]), 32'(1));
        check("m0_ack_in_frame", 32'(ack_snap - a0), 32'(1));
        check("m0_busy_after", 32'(busy[0]), 32'(0));

        // Mode 3: idle-high SCLK must not produce an edge
        check("m3_no_spurious_valid", 32'(valid_cnt[1]), 32'(0));
        tx_data[1] = 8'h81;
        xfer(1, 1, 1, 8'hF0, 8, 1'b1, 1'b1, m);
        check("m3_miso_bits", 32'(m), 32'h81);
        check("m3_rx_data", 32'(rx_data[1]), 32'hF0);
        check("m3_valid_pulses", 32'(valid_cnt[1]), 32'(1));

        // Mode 1: three back-to-back frames, host reloads after each ack
        tx_data[2] = 8'hA0;
        tx_plan[2].push_back(8'hB1);
        tx_plan[2].push_back(8'hC2);
        tx_plan[2].push_back(8'hD3);
        xfer(2, 0, 1, 8'h01, 8, 1'b1, 1'b0, m);
        check("b2b_miso_0", 32'(m), 32'hA0);
        xfer(2, 0, 1, 8'h02, 8, 1'b0, 1'b0, m);
        check("b2b_miso_1", 32'(m), 32'hB1);
        xfer(2, 0, 1, 8'h03, 8, 1'b0, 1'b1, m);
        check("b2b_miso_2", 32'(m), 32'hC2);
        check("b2b_valid_pulses", 32'(valid_cnt[2]), 32'(3));
        check("b2b_f_cnt", 32'(f_cnt[2]), 32'(3));
        check("b2b_no_err", 32'(err_cnt[2]), 32'(0));

        // Mode 0: CS raised after 5 of 8 bits, then a clean frame
        e0 = err_cnt[0];
        v0 = valid_cnt[0];
        xfer(0, 0, 0, 8'hFF, 5, 1'b1, 1'b1, m);
        check("abort_err_pulse", 32'(err_cnt[0] - e0), 32'(1));
        check("abort_no_valid", 32'(valid_cnt[0] - v0), 32'(0));
        check("abort_rx_held", 32'(rx_data[0]), 32'h3C);
        check("abort_f_cnt_held", 32'(f_cnt[0]), 32'(1));
        tx_data[0] = 8'h5A;
        xfer(0, 0, 0, 8'h55, 8, 1'b1, 1'b1, m);
        check("after_abort_rx", 32'(rx_data[0]), 32'h55);
        check("after_abort_f_cnt", 32'(f_cnt[0]), 32'(2));
        check("after_abort_err", 32'(err_cnt[0] - e0), 32'(1));

        // 2-bit frame counter wraps
        for (int k = 0; k < 5; k++) begin
            tx_data[3] = 8'(k * 17);
            xfer(3, 0, 0, 8'(8'h10 + k), 8, 1'b1, 1'b1, m);
            check($sformatf("fc2_seq[%0d]", k), 32'(f_cnt[3]), 32'(fc_seq[k]));
        end

        // Reset after bit 4 of a frame
        e0 = err_cnt[0];
        v0 = valid_cnt[0];
        xfer(0, 0, 0, 8'hAA, 4, 1'b1, 1'b0, m);
        check("pre_rst_busy", 32'(busy[0]), 32'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_rx_data", 32'(rx_data[0]), 32'(0));
        check("mid_rst_f_cnt", 32'(f_cnt[0]), 32'(0));
        check("mid_rst_busy", 32'(busy[0]), 32'(0));
        check("mid_rst_miso_oe", 32'(miso_oe[0]), 32'(0));
        check("mid_rst_miso", 32'(miso[0]), 32'(0));
        check("mid_rst_pulses", 32'({tx_ack[0], rx_valid[0], frame_err[0]}), 32'(0));
        cs[0] = 1'b1;
        wait_clk(4);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) fc_model[i] = 0;
        wait_clk(4);
        check("post_rst_no_err", 32'(err_cnt[0] - e0), 32'(0));
        check("post_rst_no_valid", 32'(valid_cnt[0] - v0), 32'(0));
        tx_data[0] = 8'h3E;
        xfer(0, 0, 0, 8'hC3, 8, 1'b1, 1'b1, m);
        check("post_rst_rx", 32'(rx_data[0]), 32'hC3);
        check("post_rst_f_cnt", 32'(f_cnt[0]), 32'(1));

        wait_clk(4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rx_q_drained[%0d]", i), 32'(rx_q[i].size()), 32'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
